dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core. It serves the core's memory-stage interface: a word address, write data, a write strobe and a combinational read data return. It holds a word RAM and a small memory-mapped I/O page. The page contains a free-running cycle counter, a debug-output FIFO drained by an external ready/valid port, and a status/error register. The core has no memory stall input, so reads complete in the same cycle and writes commit at the clock edge.

---
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: word RAM plus an MMIO page
// (cycle counter, debug FIFO with ready/valid drain, sticky status/error register).
module dmem_responder #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready
);

  localparam int          DEPTH  = 1 << FIFO_AW;
  localparam logic [29:0] W_CNT  = 30'h3FFF_C000;
  localparam logic [29:0] W_FIFO = 30'h3FFF_C001;
  localparam logic [29:0] W_ERR  = 30'h3FFF_C002;

  // ---------------- decode ----------------
  logic [29:0]        w_widx;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_ram_hit, w_cnt_hit, w_fifo_hit, w_err_hit, w_unmapped;
  logic               w_unused;

  assign w_widx     = addr[31:2];
  assign w_ram_idx  = addr[RAM_AW+1:2];
  assign w_ram_hit  = (addr[31:RAM_AW+2] == '0);
  assign w_cnt_hit  = (w_widx == W_CNT);
  assign w_fifo_hit = (w_widx == W_FIFO);
  assign w_err_hit  = (w_widx == W_ERR);
  assign w_unmapped = !(w_ram_hit || w_cnt_hit || w_fifo_hit || w_err_hit);
  assign w_unused   = ^addr[1:0];

  // ---------------- RAM (never reset; writes land even under reset) ----------------
  logic [31:0] r_ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (mem_write && w_ram_hit) r_ram[w_ram_idx] <= write_data;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                         r_cnt <= '0;
    else if (mem_write && w_cnt_hit) r_cnt <= write_data;
    else                             r_cnt <= r_cnt + 32'd1;
  end

  // ---------------- debug FIFO ----------------
  logic [31:0]        r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_rd, r_wr;
  logic [FIFO_AW:0]   r_count;
  logic               w_empty, w_full, w_pop, w_push_req, w_push_ok, w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_pop      = !w_empty && dbg_ready;
  assign w_push_req = mem_write && w_fifo_hit;
  // a pop in the same cycle frees the slot, so a full FIFO can still take the push
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok && !rst) r_fifo[r_wr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dbg_valid = !w_empty;
  assign dbg_data  = w_empty ? 32'h0 : r_fifo[r_rd];

  // ---------------- status / error ----------------
  logic [15:0] r_drop_cnt;
  logic        r_unmapped_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt     <= '0;
      r_unmapped_err <= 1'b0;
    end else if (mem_write && w_err_hit) begin
      r_drop_cnt     <= '0;
      r_unmapped_err <= 1'b0;
    end else begin
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (mem_write && w_unmapped)          r_unmapped_err <= 1'b1;
    end
  end

  // ---------------- read mux (side-effect free) ----------------
  always_comb begin
    read_data = 32'h0;
    if (w_ram_hit)       read_data = r_ram[w_ram_idx];
    else if (w_cnt_hit)  read_data = r_cnt;
    else if (w_fifo_hit) read_data = {16'h0, 8'(r_count), 6'h0, w_full, w_empty};
    else if (w_err_hit)  read_data = {r_drop_cnt, 15'h0, r_unmapped_err};
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a queue/array reference model of the memory map.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [31:0] A_CNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_FIFO = 32'hFFFF_0004;
  localparam logic [31:0] A_ERR  = 32'hFFFF_0008;
  localparam logic [31:0] A_HOLE = 32'hFFFF_000C;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready = 1'b0;

  dmem_responder #(.RAM_AW(10), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  logic [31:0] m_cnt;
  int          m_drop;
  bit          m_err;
  bit          m_known = 0;

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  // returns 0 when the expected value is unknown (RAM word never written)
  function automatic bit mread(input logic [31:0] a, output logic [31:0] d);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    d  = 32'h0;
    if (is_ram(a)) begin
      if (!m_ram.exists(int'(a[11:2]))) return 0;
      d = m_ram[int'(a[11:2])];
    end else if (wa == A_CNT)  d = m_cnt;
    else if (wa == A_FIFO) d = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == DEPTH, m_q.size() == 0};
    else if (wa == A_ERR)  d = {16'(m_drop), 15'h0, m_err};
    return 1;
  endfunction

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic rdy, input logic rs);
    logic [31:0] wa;
    bit pop, fp;
    wa = {a[31:2], 2'b00};
    if (we && is_ram(a)) m_ram[int'(a[11:2])] = wd;
    if (rs) begin
      m_cnt = 0; m_q.delete(); m_drop = 0; m_err = 0; m_known = 1;
      return;
    end
    m_cnt = (we && wa == A_CNT) ? wd : m_cnt + 1;
    pop = (m_q.size() > 0) && rdy;
    fp  = we && wa == A_FIFO;
    if (pop) void'(m_q.pop_front());
    if (fp) begin
      if (m_q.size() < DEPTH) m_q.push_back(wd);
      else if (m_drop < 16'hFFFF) m_drop++;
    end
    if (we && wa == A_ERR) begin
      m_drop = 0; m_err = 0;
    end else if (we && !is_ram(a) && wa != A_CNT && wa != A_FIFO) m_err = 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, check combinational outputs, commit model at posedge
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic rs);
    logic [31:0] d;
    mem_write = we; addr = a; write_data = wd; dbg_ready = rdy; rst = rs;
    #1;
    if (m_known) begin
      if (mread(a, d)) chk("rd_model", read_data, d);
      chk("vld_model", {31'h0, dbg_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) chk("dat_model", dbg_data, m_q[0]);
    end
    @(posedge clk);
    model_edge(we, a, wd, rdy, rs);
    @(negedge clk);
  endtask

  // side-effect-free read between edges, against a constant
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_write = 1'b0; addr = a;
    #1;
    chk(tag, read_data, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: rand_addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      4:          rand_addr = A_CNT;
      5, 6:       rand_addr = A_FIFO | 32'($urandom_range(0, 3));
      7:          rand_addr = A_ERR;
      8:          rand_addr = A_HOLE;
      default:    rand_addr = $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_tail [9];
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, A_CNT, 0, 0, 1);

    // reset state and counter start
    chk("rst_valid", {31'h0, dbg_valid}, 32'h0);
    peek("rst_fstat", A_FIFO, 32'h0000_0001);
    peek("rst_err", A_ERR, 32'h0);
    peek("cnt0", A_CNT, 32'd0);
    step(0, A_CNT, 0, 0, 0); peek("cnt1", A_CNT, 32'd1);
    step(0, A_CNT, 0, 0, 0); peek("cnt2", A_CNT, 32'd2);
    step(0, A_CNT, 0, 0, 0); peek("cnt3", A_CNT, 32'd3);

    // counter load and wrap
    step(1, A_CNT, 32'hFFFF_FFFE, 0, 0); peek("cnt_ld", A_CNT, 32'hFFFF_FFFE);
    step(0, A_CNT, 0, 0, 0);             peek("cnt_max", A_CNT, 32'hFFFF_FFFF);
    step(0, A_CNT, 0, 0, 0);             peek("cnt_wrap", A_CNT, 32'h0);

    // RAM read-before-write, out-of-range write is unmapped
    step(1, 32'h10, 32'hCAFE_F00D, 0, 0);
    mem_write = 1; addr = 32'h10; write_data = 32'h1234_5678; #1;
    chk("ram_old", read_data, 32'hCAFE_F00D);
    step(1, 32'h10, 32'h1234_5678, 0, 0);
    peek("ram_new", 32'h10, 32'h1234_5678);
    step(1, 32'h1010, 32'h5, 0, 0);
    peek("unmap_rd", 32'h1010, 32'h0);
    peek("unmap_err", A_ERR, 32'h0000_0001);
    step(1, A_ERR, 32'h0, 0, 0);
    peek("err_clr", A_ERR, 32'h0);

    // FIFO overflow then drain
    for (int i = 1; i <= 10; i++) step(1, A_FIFO, 32'(i), 0, 0);
    peek("ovf_fstat", A_FIFO, 32'h0000_0802);
    peek("ovf_err", A_ERR, 32'h0002_0000);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_vld", {31'h0, dbg_valid}, 32'h1);
      chk("drain_dat", dbg_data, 32'(i));
      step(0, A_FIFO, 0, 1, 0);
    end
    chk("drained_vld", {31'h0, dbg_valid}, 32'h0);
    peek("drained_fstat", A_FIFO, 32'h0000_0001);

    // push into empty with ready high: no pop that cycle
    step(1, A_ERR, 0, 0, 0);
    step(1, A_FIFO, 32'h55, 1, 0);
    chk("empty_push_vld", {31'h0, dbg_valid}, 32'h1);
    chk("empty_push_dat", dbg_data, 32'h55);
    step(0, A_CNT, 0, 1, 0);

    // full + simultaneous push/pop
    for (int i = 1; i <= 8; i++) step(1, A_FIFO, 32'h100 + 32'(i), 0, 0);
    step(1, A_FIFO, 32'hAA, 1, 0);
    peek("fullpp_fstat", A_FIFO, 32'h0000_0802);
    peek("fullpp_err", A_ERR, 32'h0);
    for (int i = 0; i < 8; i++) exp_tail[i] = 32'h102 + 32'(i);
    exp_tail[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      chk("fullpp_dat", dbg_data, exp_tail[i]);
      step(0, A_CNT, 0, 1, 0);
    end
    chk("fullpp_empty", {31'h0, dbg_valid}, 32'h0);

    // reset mid-operation
    step(1, A_FIFO, 32'h77, 0, 0);
    step(1, A_FIFO, 32'h78, 0, 0);
    step(1, A_HOLE, 32'h1, 0, 0);
    step(1, 32'h20, 32'hDEAD_BEEF, 0, 0);
    step(1, 32'h24, 32'h600D_D00D, 0, 1);
    peek("rst2_cnt", A_CNT, 32'h0);
    peek("rst2_fstat", A_FIFO, 32'h0000_0001);
    peek("rst2_err", A_ERR, 32'h0);
    chk("rst2_vld", {31'h0, dbg_valid}, 32'h0);
    step(0, A_CNT, 0, 0, 0);
    peek("rst2_ram_pre", 32'h20, 32'hDEAD_BEEF);
    peek("rst2_ram_dur", 32'h24, 32'h600D_D00D);
    peek("rst2_cnt1", A_CNT, 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
